// File: rtl/map_pkg.sv
// Shared types and constants for the block-map RAM arbiter.
// Fill state encoding is used only when MAP_ARBITER_FILL_EN is defined.
package map_pkg;

  localparam int MAP_ADDR_W = 15;
  localparam int MAP_DATA_W = 5;
  localparam int MAP_DEPTH  = 32768;

  typedef logic [MAP_ADDR_W-1:0] map_addr_t;
  typedef logic [MAP_DATA_W-1:0] map_data_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_t;

  typedef struct packed {
    logic valid;
    logic id;
  } rd_tag_t;

endpackage

// File: rtl/map_arbiter_if.sv
// Client request/grant/return bus plus the map RAM ports.
// slave = arbiter side, master = clients and RAM side.
interface map_arbiter_if;
  import map_pkg::*;

  logic      r0_req;
  map_addr_t r0_addr;
  logic      r0_gnt;
  logic      r0_rvalid;
  map_data_t r0_rdata;

  logic      r1_req;
  map_addr_t r1_addr;
  logic      r1_gnt;
  logic      r1_rvalid;
  map_data_t r1_rdata;

  logic      w0_req;
  map_addr_t w0_addr;
  map_data_t w0_data;
  logic      w0_gnt;

  logic      w1_req;
  map_addr_t w1_addr;
  map_data_t w1_data;
  logic      w1_gnt;

  logic      clear_start;
  map_data_t clear_data;
  logic      clear_busy;
  logic      clear_done;

  logic      ram_write_en;
  map_addr_t ram_write_addr;
  map_data_t ram_write_data;
  map_addr_t ram_block_addr;
  map_data_t ram_block_id;

  modport slave (
    input  r0_req, r0_addr,
    output r0_gnt, r0_rvalid, r0_rdata,
    input  r1_req, r1_addr,
    output r1_gnt, r1_rvalid, r1_rdata,
    input  w0_req, w0_addr, w0_data,
    output w0_gnt,
    input  w1_req, w1_addr, w1_data,
    output w1_gnt,
    input  clear_start, clear_data,
    output clear_busy, clear_done,
    output ram_write_en, ram_write_addr,
    output ram_write_data, ram_block_addr,
    input  ram_block_id
  );

  modport master (
    output r0_req, r0_addr,
    input  r0_gnt, r0_rvalid, r0_rdata,
    output r1_req, r1_addr,
    input  r1_gnt, r1_rvalid, r1_rdata,
    output w0_req, w0_addr, w0_data,
    input  w0_gnt,
    output w1_req, w1_addr, w1_data,
    input  w1_gnt,
    output clear_start, clear_data,
    input  clear_busy, clear_done,
    input  ram_write_en, ram_write_addr,
    input  ram_write_data, ram_block_addr,
    output ram_block_id
  );

endinterface

// File: rtl/map_rd_pipe.sv
// Read-return tag pipeline: one {valid, id} tag per granted read,
// emerging RD_LAT cycles later to steer the RAM data to its owner.
module map_rd_pipe
  import map_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic gnt0,
  input  logic gnt1,
  output logic rvalid0,
  output logic rvalid1
);

  rd_tag_t pipe [RD_LAT];

  // shift one tag per cycle; reset discards in-flight returns
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < RD_LAT; i++)
        pipe[i] <= '0;
    end else begin
      pipe[0] <= '{valid: gnt0 | gnt1, id: gnt1};
      for (int i = 1; i < RD_LAT; i++)
        pipe[i] <= pipe[i-1];
    end
  end

  assign rvalid0 = pipe[RD_LAT-1].valid & ~pipe[RD_LAT-1].id;
  assign rvalid1 = pipe[RD_LAT-1].valid &  pipe[RD_LAT-1].id;

endmodule

// File: rtl/map_arbiter.sv
// Map RAM arbiter: 2 readers, 2 writers, optional full-map fill
// engine enabled by defining MAP_ARBITER_FILL_EN.
module map_arbiter
  import map_pkg::*;
#(
  parameter int RD_LAT     = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic         clk,
  input  logic         rst,
  map_arbiter_if.slave bus
);

  logic      rst_q;
  logic      blk;
  logic [7:0] starve;
  logic      rd0, rd1;
  logic      wr0, wr1;
  logic      rv0, rv1;
  map_addr_t blk_addr_q;

  logic      fill_run;
  logic      fill_hold;
  logic      busy_raw;
  logic      done_raw;
  map_addr_t fill_addr;
  map_data_t fill_data;
  logic      fill_we;

  // outputs stay quiet during reset and the cycle after
  always_ff @(posedge clk) begin
    rst_q <= rst;
  end

  assign blk = rst | rst_q;

  // read arbitration: r0 first unless r1 has starved
  always_comb begin
    rd0 = 1'b0;
    rd1 = 1'b0;
    if (!blk) begin
      if (bus.r1_req && starve == 8'(STARVE_MAX))
        rd1 = 1'b1;
      else if (bus.r0_req)
        rd0 = 1'b1;
      else if (bus.r1_req)
        rd1 = 1'b1;
    end
  end

  // r1 starvation counter, saturating
  always_ff @(posedge clk) begin
    if (rst)
      starve <= '0;
    else if (!bus.r1_req || rd1)
      starve <= '0;
    else if (starve != 8'(STARVE_MAX))
      starve <= starve + 8'd1;
  end

  // last granted read address, held while idle
  always_ff @(posedge clk) begin
    if (rst)
      blk_addr_q <= '0;
    else if (rd0)
      blk_addr_q <= bus.r0_addr;
    else if (rd1)
      blk_addr_q <= bus.r1_addr;
  end

  assign bus.ram_block_addr = blk ? '0 :
                              rd0 ? bus.r0_addr :
                              rd1 ? bus.r1_addr :
                              blk_addr_q;

  assign bus.r0_gnt = rd0;
  assign bus.r1_gnt = rd1;

  map_rd_pipe #(
    .RD_LAT (RD_LAT)
  ) u_rd_pipe (
    .clk     (clk),
    .rst     (rst),
    .gnt0    (rd0),
    .gnt1    (rd1),
    .rvalid0 (rv0),
    .rvalid1 (rv1)
  );

  assign bus.r0_rvalid = rv0 & ~blk;
  assign bus.r1_rvalid = rv1 & ~blk;
  assign bus.r0_rdata  = bus.r0_rvalid ? bus.ram_block_id : '0;
  assign bus.r1_rdata  = bus.r1_rvalid ? bus.ram_block_id : '0;

`ifdef MAP_ARBITER_FILL_EN
  fill_state_t state, state_nx;
  map_addr_t   fill_cnt;

  // fill state, address counter and captured fill value
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      fill_cnt  <= '0;
      fill_data <= '0;
    end else begin
      state <= state_nx;
      if (state == ST_IDLE && bus.clear_start) begin
        fill_cnt  <= '0;
        fill_data <= bus.clear_data;
      end else if (state == ST_FILL) begin
        fill_cnt <= fill_cnt + 15'd1;
      end
    end
  end

  // fill next state; client writes locked out while it owns the port
  always_comb begin
    state_nx  = state;
    fill_run  = 1'b0;
    fill_hold = 1'b0;
    busy_raw  = 1'b0;
    done_raw  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.clear_start) begin
          state_nx  = ST_FILL;
          fill_hold = 1'b1;
        end
      end
      ST_FILL: begin
        fill_run  = 1'b1;
        fill_hold = 1'b1;
        busy_raw  = 1'b1;
        if (fill_cnt == 15'(MAP_DEPTH - 1))
          state_nx = ST_DONE;
      end
      ST_DONE: begin
        fill_hold = 1'b1;
        done_raw  = 1'b1;
        state_nx  = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  assign fill_addr = fill_cnt;
`else
  logic unused_fill;

  assign unused_fill = ^{bus.clear_start, bus.clear_data};
  assign fill_run    = 1'b0;
  assign fill_hold   = 1'b0;
  assign busy_raw    = 1'b0;
  assign done_raw    = 1'b0;
  assign fill_addr   = '0;
  assign fill_data   = '0;
`endif

  assign fill_we        = fill_run & ~blk;
  assign bus.clear_busy = busy_raw & ~blk;
  assign bus.clear_done = done_raw & ~blk;

  // write arbitration: w0 over w1, both yield to the fill
  always_comb begin
    wr0 = 1'b0;
    wr1 = 1'b0;
    if (!blk && !fill_hold) begin
      if (bus.w0_req)
        wr0 = 1'b1;
      else if (bus.w1_req)
        wr1 = 1'b1;
    end
  end

  assign bus.w0_gnt = wr0;
  assign bus.w1_gnt = wr1;

  // RAM write port mux, zero when idle
  always_comb begin
    bus.ram_write_en   = 1'b0;
    bus.ram_write_addr = '0;
    bus.ram_write_data = '0;
    if (fill_we) begin
      bus.ram_write_en   = 1'b1;
      bus.ram_write_addr = fill_addr;
      bus.ram_write_data = fill_data;
    end else if (wr0) begin
      bus.ram_write_en   = 1'b1;
      bus.ram_write_addr = bus.w0_addr;
      bus.ram_write_data = bus.w0_data;
    end else if (wr1) begin
      bus.ram_write_en   = 1'b1;
      bus.ram_write_addr = bus.w1_addr;
      bus.ram_write_data = bus.w1_data;
    end
  end

endmodule

// File: doc/map_arbiter.md
MAP_ARBITER -- requirements
Module: map_arbiter

Interface
REQ-001 Parameter RD_LAT, default 1: map RAM read latency in clk cycles from address to block_id; range 1..4.
REQ-002 Parameter STARVE_MAX, default 8: consecutive denied cycles of r1 before r1 is forced priority; range 1..255.
REQ-003 clk  in  1  single clock; all logic on posedge clk.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 r0_req/r0_addr/r0_gnt  in/in/out  1/15/1  renderer read request, block address, grant.
REQ-006 r0_rvalid/r0_rdata  out/out  1/5  renderer read return strobe, block id.
REQ-007 r1_req/r1_addr/r1_gnt  in/in/out  1/15/1  player pick read request, address, grant.
REQ-008 r1_rvalid/r1_rdata  out/out  1/5  player read return strobe, block id.
REQ-009 w0_req/w0_addr/w0_data/w0_gnt  in/in/in/out  1/15/5/1  player place/break write.
REQ-010 w1_req/w1_addr/w1_data/w1_gnt  in/in/in/out  1/15/5/1  terrain generator write.
REQ-011 clear_start/clear_data  in/in  1/5  start full-map fill, fill block id.
REQ-012 clear_busy/clear_done  out/out  1/1  fill in progress, one-cycle completion pulse.
REQ-013 ram_write_en/ram_write_addr/ram_write_data  out/out/out  1/15/5  map RAM write port.
REQ-014 ram_block_addr/ram_block_id  out/in  15/5  map RAM read port address, returned data.

Function
REQ-015 Grants are combinational from same-cycle requests; a request is served in the cycle its gnt is high; requester holds req/addr/data until granted.
REQ-016 Read port: r0 has priority over r1, except when the r1 starvation counter equals STARVE_MAX, then r1 wins that cycle.
REQ-017 Starvation counter: increments (saturating at STARVE_MAX) each cycle r1_req=1 and r1_gnt=0; clears on r1_gnt or r1_req=0.
REQ-018 ram_block_addr = granted read address; when no read granted it holds the previous value.
REQ-019 rvalid for a requester asserts exactly RD_LAT cycles after its gnt, one cycle per grant; rdata = ram_block_id in that cycle, 0 otherwise.
REQ-020 Back-to-back grants every cycle give back-to-back rvalid; no return ever dropped or reordered.
REQ-021 Write port: w0 priority over w1; ram_write_en = w0_gnt | w1_gnt | fill write; addr/data from the winner, 0 when idle.
REQ-022 Same-cycle read and write to one address: no forwarding; read returns pre-write data.
REQ-023 Fill FSM states IDLE, FILL, DONE; IDLE->FILL on clear_start; FILL writes clear_data (captured at start) to addresses 0..32767, one per cycle.
REQ-024 In FILL: clear_busy=1, w0_gnt=w1_gnt=0; reads unaffected.
REQ-025 FILL->DONE after address 32767 is written; DONE pulses clear_done for one cycle, then IDLE; total busy 32768 cycles.
REQ-026 clear_start while FILL or DONE is ignored; clear_start with writes pending in IDLE: fill wins that cycle.

Reset
REQ-027 rst for one cycle: FSM to IDLE, fill counter and starvation counter to 0, all in-flight read returns discarded.
REQ-028 While rst=1 and in the cycle after: all gnt, rvalid, rdata, clear_busy, clear_done, ram_write_en, ram_write_addr, ram_write_data, ram_block_addr = 0.
REQ-029 rst mid-fill aborts the fill with no clear_done pulse; a new clear_start restarts at address 0.

Configuration
REQ-030 Macro MAP_ARBITER_FILL_EN: defined -> fill FSM per REQ-023..026 present; undefined -> FSM absent, clear_start ignored, clear_busy=clear_done=0 always.

Structure
REQ-031 Shared package map_pkg holds MAP_ADDR_W=15, MAP_DATA_W=5, MAP_DEPTH=32768 and the fill state type.
REQ-032 Sub-module map_rd_pipe: RD_LAT-deep shift register of {valid, requester-id} tags producing r0/r1_rvalid.

Verification
REQ-033 r0_req and r1_req high 20 cycles, STARVE_MAX=8 -> r1_gnt at cycles 9 and 18, r0_gnt all others.
REQ-034 r0 reads addr 0x0010 (RAM holds 5), RD_LAT=2 -> r0_rvalid=1, r0_rdata=5 exactly 2 cycles after r0_gnt.
REQ-035 w0 (0x0100, 3) and w1 (0x0200, 7) same cycle -> w0_gnt first, w1_gnt next cycle, RAM writes in that order.
REQ-036 clear_start, clear_data=1 -> clear_busy 32768 cycles, ram_write_addr 0..32767, one clear_done pulse; w1_req held throughout is granted the cycle after DONE.
REQ-037 rst asserted at fill address 1000 -> all outputs 0, no clear_done; clear_start after reset restarts at address 0.
